// File: rtl/imem_uart_loader.sv
// imem_uart_loader: boot-time UART (8N1) loader for the instruction memory.
// Receives a 16-bit little-endian word count followed by that many 32-bit
// little-endian words, writes them to instruction memory from word 0 upward,
// and holds the core in reset until the last word is written.
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   uart_rx               serial input, idle high
//   boot_skip             sampled in IDLE; 1 skips the load entirely
//   imem_we/addr/wdata    instruction-memory write port
//   cpu_reset_n           registered active-low reset to the core
//   busy, done, error     load status; done and error are sticky
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    input  logic                  boot_skip,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;

    rx_state_t       rx_st_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q, frame_err_q;

    state_t                st_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [1:0]            lane_q;
    logic [23:0]           word_q;
    logic                  we_q, crn_q, busy_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           len_full;

    assign len_full    = {shift_q, len_q[7:0]};
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset_n = crn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;

    // UART receiver; shift_q holds the received byte while byte_valid_q pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_st_q      <= R_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_st_q)
                R_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_st_q <= R_START;
                    cnt_q   <= '0;
                end
                R_START: if (cnt_q == HALF) begin
                    // line back high at mid start bit: glitch, drop silently
                    rx_st_q <= rx_sync_q ? R_IDLE : R_DATA;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                end else cnt_q <= cnt_q + 1'b1;
                R_DATA: if (cnt_q == FULL) begin
                    cnt_q   <= '0;
                    shift_q <= {rx_sync_q, shift_q[7:1]};
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) rx_st_q <= R_STOP;
                end else cnt_q <= cnt_q + 1'b1;
                R_STOP: if (cnt_q == FULL) begin
                    cnt_q        <= '0;
                    byte_valid_q <= rx_sync_q;
                    frame_err_q  <= !rx_sync_q;
                    rx_st_q      <= R_IDLE;
                end else cnt_q <= cnt_q + 1'b1;
                default: rx_st_q <= R_IDLE;
            endcase
        end
    end

    // Loader FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (frame_err_q && (st_q == S_LEN_LO || st_q == S_LEN_HI || st_q == S_DATA)) begin
                st_q   <= S_ERROR;
                busy_q <= 1'b0;
                err_q  <= 1'b1;
            end else begin
                case (st_q)
                    S_IDLE: begin
                        st_q   <= boot_skip ? S_DONE : S_LEN_LO;
                        busy_q <= !boot_skip;
                        done_q <= boot_skip;
                    end
                    S_LEN_LO: if (byte_valid_q) begin
                        len_q[7:0] <= shift_q;
                        st_q       <= S_LEN_HI;
                    end
                    S_LEN_HI: if (byte_valid_q) begin
                        len_q[15:8] <= shift_q;
                        idx_q       <= '0;
                        lane_q      <= '0;
                        if (len_full == 16'd0) begin
                            st_q   <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else if (17'(len_full) > MAX_WORDS) begin
                            st_q   <= S_ERROR;
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                        end else st_q <= S_DATA;
                    end
                    S_DATA: if (byte_valid_q) begin
                        // lanes 0..2 shift in from the top so byte0 lands in [7:0]
                        lane_q <= lane_q + 1'b1;
                        if (lane_q == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= idx_q[ADDR_WIDTH-1:0];
                            wdata_q <= {shift_q, word_q};
                            st_q    <= S_WRITE;
                        end else word_q <= {shift_q, word_q[23:8]};
                    end
                    S_WRITE: begin
                        idx_q  <= idx_q + 1'b1;
                        lane_q <= '0;
                        if (17'(idx_q) + 17'd1 == 17'(len_q)) begin
                            st_q   <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else st_q <= S_DATA;
                    end
                    S_DONE: crn_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule
